// File: rtl/itr_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller slice.
package itr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_SERV = 2'd2,
        ST_HOLD = 2'd3
    } itr_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/itr_ctrl_if.sv
// Peripheral/core-facing signal bundle of the interrupt controller.
interface itr_ctrl_if
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 4
);
    localparam int unsigned IW = idx_w(NSRC);

    logic [NSRC-1:0] src;
    logic            inhibit;
    logic            mask_wr;
    logic            clr_wr;
    logic            eoi;
    logic            err_clr;
    logic [NSRC-1:0] cfg_data;
    logic            itr;
    logic [IW-1:0]   vec;
    logic            in_svc;
    logic [NSRC-1:0] pend;
    logic            err;

    modport slave (
        input  src, inhibit, mask_wr, clr_wr, eoi, err_clr, cfg_data,
        output itr, vec, in_svc, pend, err
    );

    modport master (
        output src, inhibit, mask_wr, clr_wr, eoi, err_clr, cfg_data,
        input  itr, vec, in_svc, pend, err
    );

endinterface

// File: rtl/itr_ctrl_prio.sv
// Combinational priority encoder: fixed (index 0 highest) or round-robin from ptr.
module itr_prio
    import itr_ctrl_pkg::*;
#(
    parameter  int unsigned NSRC  = 4,
    parameter  int unsigned RRPRI = 0,
    localparam int unsigned IW    = idx_w(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        int unsigned base;
        int unsigned j;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        base    = (RRPRI != 0) ? 32'(ptr) : 32'd0;
        // Scan NSRC slots starting at base, wrapping without a modulo.
        for (int unsigned i = 0; i < NSRC; i++) begin
            j = base + i;
            if (j >= NSRC) j = j - NSRC;
            if (!gnt_vld && req[IW'(j)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: latches source edges, masks/prioritises them and
// issues a one-cycle itr pulse, then waits for eoi (or timeout) before refiring.
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned RRPRI  = 0,
    parameter int unsigned HOLDOF = 2,
    parameter int unsigned TMOUT  = 0,
    parameter int unsigned NBTMO  = 16
) (
    input logic       clk,
    input logic       rst,
    itr_ctrl_if.slave bus
);

    localparam int unsigned       IW        = idx_w(NSRC);
    localparam int unsigned       CW        = (HOLDOF > 0) ? $clog2(HOLDOF + 1) : 1;
    localparam logic [CW-1:0]     HOLD_INIT = CW'(HOLDOF);
    localparam logic [NBTMO-1:0]  TMO_LAST  = NBTMO'(TMOUT - 1);

    itr_state_e      state_q, state_d;
    logic [NSRC-1:0] src_q, pend_q, pend_d, mask_q, eligible, clr_bits;
    logic [IW-1:0]   vec_q, vec_d, ptr_q, ptr_d, gnt_idx;
    logic            gnt_vld;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NBTMO-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            itr_q, in_svc_q;

    assign eligible = pend_q & mask_q;

    itr_prio #(
        .NSRC  (NSRC),
        .RRPRI (RRPRI)
    ) u_prio (
        .req     (eligible),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        clr_bits = bus.clr_wr ? bus.cfg_data : '0;

        if (bus.err_clr) err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld && !bus.inhibit) begin
                    state_d = ST_FIRE;
                    vec_d   = gnt_idx;
                    ptr_d   = (gnt_idx == IW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            ST_FIRE: begin
                clr_bits[vec_q] = 1'b1;
                tmo_d           = '0;
                state_d         = ST_SERV;
            end
            ST_SERV: begin
                // eoi takes precedence over a coincident timeout.
                if (bus.eoi || (TMOUT != 0 && tmo_q == TMO_LAST)) begin
                    if (!bus.eoi) err_d = 1'b1;
                    state_d = (HOLDOF == 0) ? ST_IDLE : ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge wins over any clear of the same bit.
        pend_d = (pend_q & ~clr_bits) | (bus.src & ~src_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            vec_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            itr_q    <= 1'b0;
            in_svc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= bus.src;
            pend_q   <= pend_d;
            if (bus.mask_wr) mask_q <= bus.cfg_data;
            vec_q    <= vec_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            itr_q    <= (state_d == ST_FIRE);
            in_svc_q <= (state_d == ST_FIRE) || (state_d == ST_SERV);
        end
    end

    assign bus.itr    = itr_q;
    assign bus.vec    = vec_q;
    assign bus.in_svc = in_svc_q;
    assign bus.pend   = pend_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Randomised scoreboard bench: a fixed-priority and a round-robin/timeout
// instance share stimulus and are compared against a service-timeline model.
module tb_itr_ctrl;

    localparam int NCYC = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src, cfg_data;
    logic       inhibit, mask_wr, clr_wr, eoi, err_clr;

    always #5 clk = ~clk;

    itr_ctrl_if #(.NSRC(4)) bus0 ();
    itr_ctrl_if #(.NSRC(4)) bus1 ();

    assign bus0.src = src;      assign bus1.src = src;
    assign bus0.inhibit = inhibit; assign bus1.inhibit = inhibit;
    assign bus0.mask_wr = mask_wr; assign bus1.mask_wr = mask_wr;
    assign bus0.clr_wr = clr_wr;   assign bus1.clr_wr = clr_wr;
    assign bus0.eoi = eoi;         assign bus1.eoi = eoi;
    assign bus0.err_clr = err_clr; assign bus1.err_clr = err_clr;
    assign bus0.cfg_data = cfg_data; assign bus1.cfg_data = cfg_data;

    itr_ctrl #(.NSRC(4), .RRPRI(0), .HOLDOF(2), .TMOUT(0), .NBTMO(16)) u_fix (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    itr_ctrl #(.NSRC(4), .RRPRI(1), .HOLDOF(0), .TMOUT(8), .NBTMO(16)) u_rr (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];

    // Model: per instance, pending/mask bits plus a service timeline
    // (age since grant, remaining resume gap).
    logic [3:0] m_pend[2], m_mask[2], m_prev[2];
    logic [1:0] m_vec[2];
    int         m_ptr[2], m_age[2], m_gap[2];
    bit         m_active[2], m_err[2];
    bit         did_rst = 0;
    logic [1:0] e0, e1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] el, input int start);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (start + i) % 4;
            if (el[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset(input int m);
        m_pend[m] = '0; m_mask[m] = '0; m_prev[m] = '0; m_vec[m] = '0;
        m_ptr[m] = 0; m_age[m] = 0; m_gap[m] = 0; m_active[m] = 0; m_err[m] = 0;
    endtask

    task automatic model_step(input int m, input int hold, input int tmout, input bit rr);
        logic [3:0] edges, clr, el;
        int w;
        edges = src & ~m_prev[m];
        clr   = clr_wr ? cfg_data : 4'b0000;
        if (err_clr) m_err[m] = 0;
        if (m_active[m]) begin
            if (m_age[m] == 0) begin
                clr[m_vec[m]] = 1'b1;
                m_age[m] = 1;
            end else if (eoi) begin
                m_active[m] = 0;
                m_gap[m] = hold;
            end else if (tmout > 0 && m_age[m] - 1 == tmout - 1) begin
                m_err[m] = 1;
                m_active[m] = 0;
                m_gap[m] = hold;
            end else begin
                m_age[m]++;
            end
        end else if (m_gap[m] > 0) begin
            m_gap[m]--;
        end else begin
            el = m_pend[m] & m_mask[m];
            if (el != 0 && !inhibit) begin
                w = pick(el, rr ? m_ptr[m] : 0);
                m_vec[m] = w[1:0];
                m_ptr[m] = (w + 1) % 4;
                m_active[m] = 1;
                m_age[m] = 0;
                if (m == 0) q0.push_back(m_vec[m]);
                else        q1.push_back(m_vec[m]);
            end
        end
        m_pend[m] = (m_pend[m] & ~clr) | edges;
        if (mask_wr) m_mask[m] = cfg_data;
        m_prev[m] = src;
    endtask

    task automatic check_cycle(input int m, input string tag, input logic itr_a,
                               input logic svc_a, input logic [3:0] pend_a, input logic err_a);
        chk({"itr_", tag},    32'(itr_a),  32'(m_active[m] && m_age[m] == 0));
        chk({"in_svc_", tag}, 32'(svc_a),  32'(m_active[m]));
        chk({"pend_", tag},   32'(pend_a), 32'(m_pend[m]));
        chk({"err_", tag},    32'(err_a),  32'(m_err[m]));
    endtask

    task automatic check_zero(input string tag);
        chk({"rst_itr_", tag},  32'({bus0.itr, bus1.itr}), 32'd0);
        chk({"rst_svc_", tag},  32'({bus0.in_svc, bus1.in_svc}), 32'd0);
        chk({"rst_pend_", tag}, 32'({bus0.pend, bus1.pend}), 32'd0);
        chk({"rst_err_", tag},  32'({bus0.err, bus1.err}), 32'd0);
        chk({"rst_vec_", tag},  32'({bus0.vec, bus1.vec}), 32'd0);
    endtask

    task automatic randomize_inputs(input int it);
        logic [31:0] r;
        r        = $urandom;
        src      = src ^ (r[3:0] & r[7:4]);
        inhibit  = ($urandom_range(0, 3) == 0);
        eoi      = ($urandom_range(0, 5) == 0);
        err_clr  = ($urandom_range(0, 24) == 0);
        mask_wr  = (it >= 40) && ($urandom_range(0, 15) == 0);
        clr_wr   = ($urandom_range(0, 19) == 0);
        cfg_data = 4'($urandom);
        // Close the mask at the end so no grant is left unobserved.
        if (it >= NCYC - 4) begin
            mask_wr  = 1'b1;
            clr_wr   = 1'b0;
            cfg_data = 4'b0000;
        end
    endtask

    // Scoreboard monitor: every itr pulse must match the oldest predicted grant.
    always @(negedge clk) begin
        if (!rst && bus0.itr) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL itr_unexpected_fix: vec=%0d but no grant expected at %0t", bus0.vec, $time);
            end else begin
                e0 = q0.pop_front();
                chk("vec_fix", 32'(bus0.vec), 32'(e0));
            end
        end
        if (!rst && bus1.itr) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL itr_unexpected_rr: vec=%0d but no grant expected at %0t", bus1.vec, $time);
            end else begin
                e1 = q1.pop_front();
                chk("vec_rr", 32'(bus1.vec), 32'(e1));
            end
        end
    end

    initial begin
        src = '0; cfg_data = '0; inhibit = 0; mask_wr = 0; clr_wr = 0; eoi = 0; err_clr = 0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_zero("init");
        rst = 1'b0;

        for (int it = 0; it < NCYC; it++) begin
            @(negedge clk);
            check_cycle(0, "fix", bus0.itr, bus0.in_svc, bus0.pend, bus0.err);
            check_cycle(1, "rr",  bus1.itr, bus1.in_svc, bus1.pend, bus1.err);
            if (!did_rst && it > 1000 && m_active[0] && m_age[0] > 0) begin
                #2 rst = 1'b1;
                #1 check_zero("async");
                model_reset(0);
                model_reset(1);
                q0.delete();
                q1.delete();
                did_rst = 1;
                @(negedge clk);
                check_zero("held");
                rst = 1'b0;
            end
            randomize_inputs(it);
            model_step(0, 2, 0, 1'b0);
            model_step(1, 0, 8, 1'b1);
        end

        @(negedge clk);
        check_cycle(0, "fix", bus0.itr, bus0.in_svc, bus0.pend, bus0.err);
        check_cycle(1, "rr",  bus1.itr, bus1.in_svc, bus1.pend, bus1.err);
        #2;
        chk("drain_fix", 32'(q0.size()), 32'd0);
        chk("drain_rr",  32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
